// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Generates 640x480@60 VGA timing from the system clock, advancing one
//   pixel every TICK_DIV clocks. Each coordinate is held for exactly
//   TICK_DIV clocks. A new coordinate appears on the first clock of its
//   period (div == 0). This matches the phase of the downstream 4-state
//   in-circle comparator loop.
//
// Ports
//   clk          system clock (100 MHz)
//   reset        synchronous, active-high
//   pixel_x      horizontal count, 0..H_TOTAL-1
//   pixel_y      vertical count, 0..V_TOTAL-1
//   pixel_tick   high on the last clock of each pixel period
//   video_on     high while pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
//   hsync        active-low horizontal sync
//   vsync        active-low vertical sync
//   frame_start  one-clock pulse on the first clock of pixel (0,0)
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_tick,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [3:0] DIV_LAST = 4'(TICK_DIV - 1);

    logic [3:0] div;
    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       div_last;

    assign div_last = (div == DIV_LAST);

    // Next coordinate: advances only on the last clock of a pixel period.
    always_comb begin
        h_next = h;
        v_next = v;
        if (div_last) begin
            if (h == H_LAST) begin
                h_next = '0;
                if (v == V_LAST) begin
                    v_next = '0;
                end else begin
                    v_next = v + 10'd1;
                end
            end else begin
                h_next = h + 10'd1;
            end
        end
    end

    // Syncs and blanking are decoded from the next-state coordinate so they
    // change on the same edge as pixel_x/pixel_y, with no skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= '0;
            h        <= '0;
            v        <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b1;
        end else begin
            div      <= div_last ? '0 : div + 4'd1;
            h        <= h_next;
            v        <= v_next;
            hsync    <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
            vsync    <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
            video_on <= (h_next < H_VIS) && (v_next < V_VIS);
        end
    end

    assign pixel_x     = h;
    assign pixel_y     = v;
    assign pixel_tick  = div_last;
    assign frame_start = (h == '0) && (v == '0) && (div == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two instances: one at full 640x480 timing (start-up and first-line
//   behaviour) and one with a small raster so whole frames fit in a short run.
//   A reference model derives every output from the number of clocks since
//   reset release.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: default 640x480, TICK_DIV=4 ----------------
    logic       rst_a = 1'b1;
    logic [9:0] x_a, y_a;
    logic       tick_a, von_a, hs_a, vs_a, fs_a;

    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a),
        .pixel_x(x_a), .pixel_y(y_a), .pixel_tick(tick_a),
        .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    // ---------------- instance B: 8x6 visible, 15x13 total, TICK_DIV=3 -------
    logic       rst_b = 1'b1;
    logic [9:0] x_b, y_b;
    logic       tick_b, von_b, hs_b, vs_b, fs_b;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .TICK_DIV(3)
    ) dut_b (
        .clk(clk), .reset(rst_b),
        .pixel_x(x_b), .pixel_y(y_b), .pixel_tick(tick_b),
        .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    // Expected outputs after t clocks of free running since reset release,
    // packed as {x, y, tick, video_on, hsync, vsync, frame_start}.
    function automatic logic [24:0] model(input int t,
                                          input int hd, input int hf, input int hsw, input int hb,
                                          input int vd, input int vf, input int vsw, input int vb,
                                          input int td);
        int ht, vt, pix, x, y, d;
        logic tk, von, hs, vs, fs;
        ht  = hd + hf + hsw + hb;
        vt  = vd + vf + vsw + vb;
        pix = t / td;
        d   = t % td;
        x   = pix % ht;
        y   = (pix / ht) % vt;
        tk  = (d == td - 1);
        von = (x < hd) && (y < vd);
        hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
        vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
        fs  = (x == 0) && (y == 0) && (d == 0);
        return {x[9:0], y[9:0], tk, von, hs, vs, fs};
    endfunction

    // Clocks since the last reset edge, per instance.
    int  ta = 0, tb = 0;
    bit  en_a = 1'b0, en_b = 1'b0;

    always @(posedge clk) begin
        ta <= rst_a ? 0 : ta + 1;
        tb <= rst_b ? 0 : tb + 1;
    end

    always @(negedge clk) begin
        logic [24:0] exp_v, got_v;
        if (en_a) begin
            exp_v = model(ta, 640, 16, 96, 48, 480, 10, 2, 33, 4);
            got_v = {x_a, y_a, tick_a, von_a, hs_a, vs_a, fs_a};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL model_a t=%0d got=%h exp=%h", ta, got_v, exp_v);
            end
        end
        if (en_b) begin
            exp_v = model(tb, 8, 2, 3, 2, 6, 2, 2, 3, 3);
            got_v = {x_b, y_b, tick_b, von_b, hs_b, vs_b, fs_b};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL model_b t=%0d got=%h exp=%h", tb, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
        end
    endtask

    int  hcnt, hfirst, vcnt, voncnt, npulse, prev_fs;
    bit  found;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        en_a = 1'b1;
        en_b = 1'b1;

        // ---- A: start-up sequence and first line ----
        @(negedge clk);
        chk("a_rst_x", x_a, 0);
        chk("a_rst_y", y_a, 0);
        chk("a_rst_fs", fs_a, 1);
        chk("a_rst_tick", tick_a, 0);
        chk("a_rst_hs", hs_a, 1);
        chk("a_rst_vs", vs_a, 1);
        chk("a_rst_von", von_a, 1);
        rst_a  = 1'b0;
        hcnt   = 0;
        hfirst = -1;
        for (int c = 1; c <= 3200; c++) begin
            @(negedge clk);
            if (c == 1) chk("a_fs_drop_c1", fs_a, 0);
            if (c == 2) chk("a_tick_c2", tick_a, 0);
            if (c == 3) chk("a_tick_c3", tick_a, 1);
            if (c == 3) chk("a_x_c3", x_a, 0);
            if (c == 4) chk("a_x_c4", x_a, 1);
            if (c == 8) chk("a_x_c8", x_a, 2);
            if (c < 3200 && !hs_a) begin
                if (hfirst < 0) hfirst = x_a;
                hcnt++;
            end
            if (c == 3199) begin
                chk("a_x_c3199", x_a, 799);
                chk("a_y_c3199", y_a, 0);
            end
            if (c == 3200) begin
                chk("a_x_wrap", x_a, 0);
                chk("a_y_wrap", y_a, 1);
            end
        end
        chk("a_hsync_low_clocks", hcnt, 384);
        chk("a_hsync_first_x", hfirst, 656);

        // ---- B: whole frames ----
        @(negedge clk);
        chk("b_rst_fs", fs_b, 1);
        vcnt    = vs_b ? 0 : 1;
        voncnt  = von_b ? 1 : 0;
        npulse  = 0;
        prev_fs = 0;
        rst_b   = 1'b0;
        for (int c = 1; c <= 1800; c++) begin
            @(negedge clk);
            if (c < 585) begin
                if (!vs_b) vcnt++;
                if (von_b) voncnt++;
            end
            if (c == 584) begin
                chk("b_x_last", x_b, 14);
                chk("b_y_last", y_b, 12);
            end
            if (c == 585) begin
                chk("b_x_frame_wrap", x_b, 0);
                chk("b_y_frame_wrap", y_b, 0);
            end
            if (fs_b) begin
                chk("b_fs_interval", c - prev_fs, 585);
                prev_fs = c;
                npulse++;
            end
        end
        chk("b_fs_pulses", npulse, 3);
        chk("b_vsync_low_clocks", vcnt, 90);
        chk("b_video_on_clocks", voncnt, 144);

        // ---- B: reset mid-frame at (11,8), last clock of the pixel ----
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(negedge clk);
            if (x_b == 10'd11 && y_b == 10'd8 && tick_b) found = 1'b1;
        end
        chk("b_reach_11_8", found, 1);
        chk("b_pre_hs", hs_b, 0);
        chk("b_pre_vs", vs_b, 0);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("b_mid_x", x_b, 0);
        chk("b_mid_y", y_b, 0);
        chk("b_mid_hs", hs_b, 1);
        chk("b_mid_vs", vs_b, 1);
        chk("b_mid_von", von_b, 1);
        chk("b_mid_fs", fs_b, 1);
        chk("b_mid_tick", tick_b, 0);
        repeat (2) @(negedge clk);
        chk("b_mid_tick_c2", tick_b, 1);
        @(negedge clk);
        chk("b_mid_x_c3", x_b, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
